// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM types: machine word and the RAM handshake state.
package cpu_types_pkg;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

// File: rtl/memory_arbiter_pkg.sv
// Arbiter FSM state encoding.
package memory_arbiter_pkg;
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;
endpackage

// File: rtl/memory_arbiter_rr_select.sv
// Round-robin pick of the first requesting CPU at or after ptr_i, wrapping.
// Purely combinational; no state, no backpressure.
module rr_select #(
    parameter int CPUS = 2,
    parameter int IDXW = (CPUS > 1) ? $clog2(CPUS) : 1
) (
    input  logic [CPUS-1:0] req_i,
    input  logic [IDXW-1:0] ptr_i,
    output logic            any_o,
    output logic [IDXW-1:0] idx_o
);
    int k;

    // Walk from the farthest offset down so the nearest requester is written last.
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        k     = 0;
        for (int off = CPUS - 1; off >= 0; off--) begin
            k = (int'(ptr_i) + off) % CPUS;
            if (req_i[k]) begin
                any_o = 1'b1;
                idx_o = IDXW'(k);
            end
        end
    end
endmodule

// File: rtl/memory_arbiter.sv
// Round-robin RAM arbiter for CPUS I/D cache pairs; grant registered, RAM driven cycle after request.
// Requesters stall (wait=1) until RAM ACCESS; one IDLE bubble after every transaction.
module memory_arbiter
    import cpu_types_pkg::*;
    import memory_arbiter_pkg::*;
#(
    parameter int CPUS = 2,
    parameter int IDXW = (CPUS > 1) ? $clog2(CPUS) : 1
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [CPUS-1:0] iREN,
    input  logic [CPUS-1:0] dREN,
    input  logic [CPUS-1:0] dWEN,
    input  word_t           iaddr  [CPUS],
    input  word_t           daddr  [CPUS],
    input  word_t           dstore [CPUS],
    output logic [CPUS-1:0] iwait,
    output logic [CPUS-1:0] dwait,
    output word_t           iload  [CPUS],
    output word_t           dload  [CPUS],
    input  ramstate_t       ramstate,
    input  word_t           ramload,
    output logic            ramREN,
    output logic            ramWEN,
    output word_t           ramaddr,
    output word_t           ramstore
);
    arb_state_t      state_q;
    logic [IDXW-1:0] gnt_cpu_q;
    logic            gnt_data_q;
    logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;

    logic [CPUS-1:0] cpu_req;
    logic            sel_any;
    logic [IDXW-1:0] sel_idx;

    assign cpu_req = iREN | dREN | dWEN;

    rr_select #(.CPUS(CPUS), .IDXW(IDXW)) u_rr_select (
        .req_i (cpu_req),
        .ptr_i (rr_ptr_q),
        .any_o (sel_any),
        .idx_o (sel_idx)
    );

    logic in_gnt, g_wen, g_dren, g_iren, g_req, done;

    assign in_gnt = (state_q == GRANT);
    assign g_wen  = dWEN[gnt_cpu_q];
    assign g_dren = dREN[gnt_cpu_q] & ~dWEN[gnt_cpu_q];
    assign g_iren = iREN[gnt_cpu_q];
    assign g_req  = gnt_data_q ? (dREN[gnt_cpu_q] | dWEN[gnt_cpu_q]) : g_iren;
    assign done   = in_gnt && (ramstate == ACCESS);

    // Strobes follow the live granted request, so a dropped request aborts immediately.
    assign ramWEN   = in_gnt & gnt_data_q & g_wen;
    assign ramREN   = in_gnt & (gnt_data_q ? g_dren : g_iren);
    assign ramaddr  = !in_gnt ? '0 : (gnt_data_q ? daddr[gnt_cpu_q] : iaddr[gnt_cpu_q]);
    assign ramstore = ramWEN ? dstore[gnt_cpu_q] : '0;

    assign rr_ptr_d = (int'(gnt_cpu_q) == CPUS - 1) ? '0 : gnt_cpu_q + 1'b1;

    always_comb begin
        iwait = '1;
        dwait = '1;
        for (int i = 0; i < CPUS; i++) begin
            iload[i] = '0;
            dload[i] = '0;
        end
        if (done) begin
            if (gnt_data_q) begin
                dwait[gnt_cpu_q] = 1'b0;
                if (ramREN) dload[gnt_cpu_q] = ramload;
            end else begin
                iwait[gnt_cpu_q] = 1'b0;
                if (ramREN) iload[gnt_cpu_q] = ramload;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            gnt_cpu_q  <= '0;
            gnt_data_q <= 1'b0;
            rr_ptr_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_any) begin
                        state_q    <= GRANT;
                        gnt_cpu_q  <= sel_idx;
                        gnt_data_q <= dREN[sel_idx] | dWEN[sel_idx];
                    end
                end
                GRANT: begin
                    if (ramstate == ACCESS) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= rr_ptr_d;
                    end else if (!g_req) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter with two CPUs.
module tb_memory_arbiter;
    import cpu_types_pkg::*;
    import memory_arbiter_pkg::*;

    logic       CLK;
    logic       nRST;
    logic [1:0] iREN, dREN, dWEN;
    word_t      iaddr [2];
    word_t      daddr [2];
    word_t      dstore [2];
    logic [1:0] iwait, dwait;
    word_t      iload [2];
    word_t      dload [2];
    ramstate_t  ramstate;
    word_t      ramload;
    logic       ramREN, ramWEN;
    word_t      ramaddr, ramstore;

    int checks;
    int failures;

    memory_arbiter #(.CPUS(2)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .iaddr    (iaddr),
        .daddr    (daddr),
        .dstore   (dstore),
        .iwait    (iwait),
        .dwait    (dwait),
        .iload    (iload),
        .dload    (dload),
        .ramstate (ramstate),
        .ramload  (ramload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        iREN = '0; dREN = '0; dWEN = '0;
        for (int i = 0; i < 2; i++) begin
            iaddr[i] = '0; daddr[i] = '0; dstore[i] = '0;
        end
        ramstate = FREE;
        ramload  = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            #1;
            checks++;
            if ({iwait, dwait, ramREN, ramWEN} !== 6'b111100 || ramaddr !== 32'h0 ||
                iload[0] !== 32'h0 || iload[1] !== 32'h0 || dload[0] !== 32'h0 || dload[1] !== 32'h0) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d got iwait=%b dwait=%b ren=%b wen=%b addr=%h need 11 11 0 0 0",
                         c, iwait, dwait, ramREN, ramWEN, ramaddr);
            end
        end
    endtask

    task automatic test_single_read();
        step();
        iREN[1] = 1'b1; iaddr[1] = 32'h40; ramstate = BUSY;
        #1;
        checks++;
        if (ramREN !== 1'b0) begin
            failures++; $display("FAIL read_t_idle got ramREN=%b need 0", ramREN);
        end
        for (int c = 1; c <= 2; c++) begin
            step(); #1;
            checks++;
            if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40 || iwait !== 2'b11) begin
                failures++;
                $display("FAIL read_busy t+%0d got ren=%b wen=%b addr=%h iwait=%b need 1 0 40 11",
                         c, ramREN, ramWEN, ramaddr, iwait);
            end
        end
        step();
        ramstate = ACCESS; ramload = 32'hDEADBEEF;
        #1;
        checks++;
        if (iwait !== 2'b01 || iload[1] !== 32'hDEADBEEF || iload[0] !== 32'h0 || dwait !== 2'b11) begin
            failures++;
            $display("FAIL read_access got iwait=%b iload1=%h dwait=%b need 01 deadbeef 11", iwait, iload[1], dwait);
        end
        step();
        iREN[1] = 1'b0; ramstate = FREE;
        #1;
        checks++;
        if (dut.state_q !== IDLE || ramREN !== 1'b0 || iwait !== 2'b11 || iload[1] !== 32'h0) begin
            failures++;
            $display("FAIL read_after got state=%0d ren=%b iwait=%b iload1=%h need IDLE 0 11 0",
                     dut.state_q, ramREN, iwait, iload[1]);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_dwait;
        logic       exp_ren;
        word_t      exp_addr;
        step();
        dREN = 2'b11; daddr[0] = 32'h100; daddr[1] = 32'h200;
        ramstate = ACCESS; ramload = 32'h0BADF00D;
        for (int k = 0; k < 8; k++) begin
            if (k != 0) step();
            #1;
            if (k % 2 == 0) begin
                exp_dwait = 2'b11; exp_ren = 1'b0; exp_addr = 32'h0;
            end else if (((k - 1) / 2) % 2 == 0) begin
                exp_dwait = 2'b10; exp_ren = 1'b1; exp_addr = 32'h100;
            end else begin
                exp_dwait = 2'b01; exp_ren = 1'b1; exp_addr = 32'h200;
            end
            checks++;
            if (dwait !== exp_dwait || ramREN !== exp_ren || ramaddr !== exp_addr) begin
                failures++;
                $display("FAIL round_robin cycle=%0d got dwait=%b ren=%b addr=%h need %b %b %h",
                         k, dwait, ramREN, ramaddr, exp_dwait, exp_ren, exp_addr);
            end
        end
        step();
        dREN = 2'b00; ramstate = FREE;
    endtask

    task automatic test_d_over_i();
        step();
        iREN = 2'b11; dREN[0] = 1'b1; dWEN[0] = 1'b1;
        daddr[0] = 32'h80; dstore[0] = 32'h1234; iaddr[0] = 32'h10; iaddr[1] = 32'h50;
        ramstate = ACCESS; ramload = 32'hCAFE0001;
        step(); #1;
        checks++;
        if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'h1234 || ramaddr !== 32'h80 ||
            dwait !== 2'b10 || iwait !== 2'b11 || dload[0] !== 32'h0) begin
            failures++;
            $display("FAIL d_write got wen=%b ren=%b store=%h addr=%h dwait=%b iwait=%b dload0=%h need 1 0 1234 80 10 11 0",
                     ramWEN, ramREN, ramstore, ramaddr, dwait, iwait, dload[0]);
        end
        step();
        dREN[0] = 1'b0; dWEN[0] = 1'b0;
        step(); #1;
        checks++;
        if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h50 || iwait !== 2'b01 || iload[1] !== 32'hCAFE0001) begin
            failures++;
            $display("FAIL i1_next got ren=%b wen=%b addr=%h iwait=%b iload1=%h need 1 0 50 01 cafe0001",
                     ramREN, ramWEN, ramaddr, iwait, iload[1]);
        end
        step();
        iREN[1] = 1'b0;
        step(); #1;
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h10 || iwait !== 2'b10 || iload[0] !== 32'hCAFE0001) begin
            failures++;
            $display("FAIL i0_last got ren=%b addr=%h iwait=%b iload0=%h need 1 10 10 cafe0001",
                     ramREN, ramaddr, iwait, iload[0]);
        end
        step();
        iREN[0] = 1'b0; ramstate = FREE;
    endtask

    task automatic test_abort_stall();
        step();
        dREN[1] = 1'b1; daddr[1] = 32'h300; ramstate = BUSY;
        step(); #1;
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h300 || dwait !== 2'b11) begin
            failures++;
            $display("FAIL abort_grant got ren=%b addr=%h dwait=%b need 1 300 11", ramREN, ramaddr, dwait);
        end
        step();
        dREN[1] = 1'b0;
        #1;
        checks++;
        if (ramREN !== 1'b0 || ramWEN !== 1'b0 || dwait !== 2'b11) begin
            failures++;
            $display("FAIL abort_drop got ren=%b wen=%b dwait=%b need 0 0 11", ramREN, ramWEN, dwait);
        end
        step(); #1;
        checks++;
        if (dut.state_q !== IDLE || dut.rr_ptr_q !== 1'b1) begin
            failures++;
            $display("FAIL abort_idle got state=%0d rr_ptr=%0d need IDLE 1", dut.state_q, dut.rr_ptr_q);
        end
        dREN[0] = 1'b1; daddr[0] = 32'h400; ramstate = ERROR;
        for (int c = 0; c < 3; c++) begin
            step(); #1;
            checks++;
            if (dut.state_q !== GRANT || ramREN !== 1'b1 || ramaddr !== 32'h400 || dwait !== 2'b11) begin
                failures++;
                $display("FAIL error_stall cycle=%0d got state=%0d ren=%b addr=%h dwait=%b need GRANT 1 400 11",
                         c, dut.state_q, ramREN, ramaddr, dwait);
            end
        end
    endtask

    task automatic test_reset_mid();
        #2;
        nRST = 1'b0;
        #1;
        checks++;
        if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 32'h0 || ramstore !== 32'h0 ||
            dwait !== 2'b11 || iwait !== 2'b11 || dut.state_q !== IDLE || dut.rr_ptr_q !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got ren=%b wen=%b addr=%h dwait=%b state=%0d rr=%0d need 0 0 0 11 IDLE 0",
                     ramREN, ramWEN, ramaddr, dwait, dut.state_q, dut.rr_ptr_q);
        end
        ramstate = ACCESS;
        for (int c = 0; c < 2; c++) begin
            step(); #1;
            checks++;
            if (dwait !== 2'b11 || dload[0] !== 32'h0 || ramREN !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold cycle=%0d got dwait=%b dload0=%h ren=%b need 11 0 0",
                         c, dwait, dload[0], ramREN);
            end
        end
        dREN = '0;
        ramstate = FREE;
        @(negedge CLK);
        nRST = 1'b1;
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_d_over_i();
        test_abort_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Parametrised RAM arbiter that sits between `CPUS` caches (one instruction and one data port each) and the single-ported RAM. It grants one requester per transaction, chosen by round-robin over CPUs with data ahead of instruction within a CPU. It holds the grant in a registered state machine until RAM reports `ACCESS`. It replaces the single-CPU combinational controller and adds fairness, request locking and abort handling.

## Interface
Parameters:
- `CPUS`, 2, number of cache pairs; legal range 1–8.
- `IDXW`, `$clog2(CPUS)` (1 when `CPUS`=1), width of the CPU index.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `nRST`  in  1  reset; one clock; asynchronous, active-low.
- `iREN[CPUS]`  in  1 each  instruction read request.
- `dREN[CPUS]`, `dWEN[CPUS]`  in  1 each  data read / write request.
- `iaddr[CPUS]`, `daddr[CPUS]`, `dstore[CPUS]`  in  word_t each  addresses and write data.
- `iwait[CPUS]`, `dwait[CPUS]`  out  1 each  1 = stall; 0 = transaction completes this cycle.
- `iload[CPUS]`, `dload[CPUS]`  out  word_t each  read data.
- `ramstate`  in  ramstate_t  FREE / BUSY / ACCESS / ERROR.
- `ramload`  in  word_t  RAM read data.
- `ramREN`, `ramWEN`  out  1  RAM strobes.
- `ramaddr`, `ramstore`  out  word_t  RAM address and write data.

## Operation
Requester encoding:
- Data port of CPU *i* is "D*i*"; it requests when `dREN[i]|dWEN[i]`.
- Instruction port is "I*i*"; it requests when `iREN[i]`.

Priority and fairness:
- Search order starts at CPU `rr_ptr` and wraps upward modulo `CPUS`.
- The first CPU with any request wins.
- Within that CPU, D beats I.

FSM states:
- **IDLE**: the RAM bus is idle. If any request exists, latch the winner (`gnt_cpu`, `gnt_data`) and go to **GRANT**. Otherwise stay in IDLE.
- **GRANT**: drive the RAM from the latched winner:
  - D with `dWEN`: `ramWEN`=1, `ramaddr`=`daddr`, `ramstore`=`dstore`.
  - D with `dREN`: `ramREN`=1, `ramaddr`=`daddr`.
  - I: `ramREN`=1, `ramaddr`=`iaddr`.
  - When `dWEN` and `dREN` are both high, the request is a write.

Completion:
- In a GRANT cycle with `ramstate==ACCESS`, the granted wait is 0 for that cycle.
- On a read, the granted load equals `ramload` in that cycle.
- Next state is IDLE, and `rr_ptr` ← `gnt_cpu`+1 (wraps to 0).

Abort:
- If the granted request line falls while in GRANT, with no ACCESS that cycle, drop the RAM strobes combinationally.
- Next state is IDLE. `rr_ptr` is unchanged.

Other rules:
- `ERROR` and `BUSY` are both treated as "not done": stay in GRANT and keep all waits at 1.
- All non-granted waits are 1 at all times. All non-granted loads are 0.
- The granted load is 0 outside its ACCESS cycle.

Reset values:
- State IDLE, `rr_ptr`=0.
- `ramREN`=`ramWEN`=0, `ramaddr`=`ramstore`=0.
- All waits 1, all loads 0.
- Reset asserted mid-transaction abandons it immediately, with no completion pulse.

## Timing
- A request visible in cycle *t* (IDLE) drives the RAM from cycle *t*+1.
- With a zero-wait RAM (ACCESS in *t*+1), the wait is 0 in *t*+1.
- Each transaction is followed by exactly one IDLE bubble cycle. Peak throughput is one transaction per 2 cycles.
- RAM outputs are functions of registered state plus the granted inputs only. There is no combinational path from a non-granted request to the RAM.
- The grant is stable for the whole GRANT interval. New requests arriving mid-transaction never change `gnt_cpu` or `gnt_data`.
- Starvation bound: a continuously asserted request completes within `CPUS` transactions. The exception is I*i* versus D*i* of the same CPU, where D holds priority.

## Structure
- `cpu_types_pkg` (existing) supplies `word_t` and `ramstate_t`.
- New `memory_arbiter_pkg` holds `arb_state_t` (IDLE, GRANT).
- Sub-module `rr_select`, purely combinational:
  - inputs: request vector `[CPUS]` and `rr_ptr`;
  - outputs: `any` and winner index.
- The D-over-I choice and the FSM stay in `memory_arbiter`.

## Test plan
- **Reset/idle**: hold `nRST`=0, then release with no requests → all waits 1, loads 0, `ramREN`/`ramWEN`=0, `ramaddr`=0 for 10 cycles.
- **Single read**, `CPUS`=2:
  - stimulus: `iREN[1]`=1, `iaddr[1]`=0x40; RAM answers ACCESS after 2 BUSY cycles with `ramload`=0xDEADBEEF;
  - required: `ramREN`=1, `ramaddr`=0x40 from *t*+1; `iwait[1]`=0 only in *t*+3 with `iload[1]`=0xDEADBEEF; IDLE in *t*+4.
- **Round-robin**:
  - stimulus: `dREN[0]` and `dREN[1]` held high continuously, zero-wait RAM;
  - required: grants alternate CPU0, CPU1, CPU0, …; `dwait` pulses strictly alternate every 2 cycles.
- **D over I, write precedence**:
  - stimulus: CPU0 with `iREN`, `dREN` and `dWEN` all set, `daddr`=0x80, `dstore`=0x1234;
  - required: the first transaction is a write (`ramWEN`=1, `ramstore`=0x1234, `ramREN`=0); the I fetch is serviced next, after CPU1 if CPU1 is requesting.
- **Abort and stall**:
  - stimulus: drop `dREN[1]` while the RAM is BUSY;
  - required: strobes fall in the same cycle, IDLE next cycle, `rr_ptr` unchanged;
  - stimulus: RAM reports ERROR;
  - required: the FSM stays in GRANT with wait=1.
- **Reset mid-transaction**:
  - stimulus: assert `nRST` asynchronously, between clock edges, while in GRANT;
  - required: outputs reach reset values before the next edge; no wait=0 pulse is seen.
